// File: rtl/pi_frame_rx.sv
// GPIO byte framer for Pi image frames.
// Sequences pixel writes, checks trailing sum, aborts on stall or resync.
module pi_frame_rx #(
  parameter int HEIGHT  = 20,
  parameter int WIDTH   = 30,
  parameter int DEPTH   = 3,
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 4096
) (
  input  logic              pi_clk,
  input  logic              rst_n,
  input  logic [7:0]        gpio_pin,
  input  logic              pi_valid,
  input  logic              pi_sof,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_count
);

  localparam int N  = HEIGHT * WIDTH * DEPTH;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHK
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;
  logic              done_d;
  logic              err_d;
  logic [7:0]        cnt_d;
  logic              sof_hit;
  logic              byte_hit;
  logic              in_frame;

  assign sof_hit  = pi_valid & pi_sof;
  assign byte_hit = pi_valid & ~pi_sof;
  assign in_frame = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    tmo_d     = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_d     = frame_count;
    unique case (1'b1)
      sof_hit: begin
        // a SOF mid-frame drops the old frame and restarts here
        err_d     = in_frame;
        wr_en_d   = 1'b1;
        wr_addr_d = '0;
        wr_data_d = gpio_pin;
        sum_d     = gpio_pin;
        idx_d     = IW'(1);
        state_d   = (N == 1) ? CHK : RECV;
      end
      byte_hit && state_q == RECV: begin
        wr_en_d   = 1'b1;
        wr_addr_d = idx_q[ADDR_W-1:0];
        wr_data_d = gpio_pin;
        sum_d     = sum_q + gpio_pin;
        idx_d     = idx_q + IW'(1);
        if (idx_q == IW'(N - 1))
          state_d = CHK;
      end
      byte_hit && state_q == CHK: begin
        if (gpio_pin == sum_q) begin
          done_d = 1'b1;
          cnt_d  = frame_count + 8'd1;
        end else begin
          err_d  = 1'b1;
        end
        state_d = IDLE;
      end
      !pi_valid && in_frame: begin
        if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d   = tmo_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      busy        <= (state_d != IDLE);
      frame_done  <= done_d;
      frame_err   <= err_d;
      frame_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pi_frame_rx.sv
// Directed bench for pi_frame_rx on a 4x5x3 (60-byte) frame.
// Expected counts, addresses and checksums are hand-derived.
module tb_pi_frame_rx;

  localparam int H  = 4;
  localparam int W  = 5;
  localparam int D  = 3;
  localparam int AW = 6;
  localparam int TO = 4096;
  localparam int N  = H * W * D;

  logic          pi_clk = 1'b0;
  logic          rst_n;
  logic [7:0]    gpio_pin;
  logic          pi_valid;
  logic          pi_sof;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          frame_done;
  logic          frame_err;
  logic [7:0]    frame_count;

  pi_frame_rx #(
    .HEIGHT (H),
    .WIDTH  (W),
    .DEPTH  (D),
    .ADDR_W (AW),
    .TIMEOUT(TO)
  ) dut (
    .pi_clk     (pi_clk),
    .rst_n      (rst_n),
    .gpio_pin   (gpio_pin),
    .pi_valid   (pi_valid),
    .pi_sof     (pi_sof),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  always #5 pi_clk = ~pi_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr, n_done, n_err, n_both;
  int err_wen, err_addr;
  int log_addr[$];
  int log_data[$];

  always @(negedge pi_clk) begin
    if (wr_en) begin
      n_wr++;
      log_addr.push_back(int'(wr_addr));
      log_data.push_back(int'(wr_data));
    end
    if (frame_done) n_done++;
    if (frame_err) begin
      n_err++;
      err_wen  = int'(wr_en);
      err_addr = int'(wr_addr);
    end
    if (frame_done && frame_err) n_both++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic clr();
    n_wr     = 0;
    n_done   = 0;
    n_err    = 0;
    err_wen  = -1;
    err_addr = -1;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send(input logic [7:0] b,
                      input logic sof);
    gpio_pin = b;
    pi_valid = 1'b1;
    pi_sof   = sof;
    @(posedge pi_clk);
    #1;
    pi_valid = 1'b0;
    pi_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pi_clk);
    #1;
  endtask

  // inc=1: pixel i = i, else all ones
  task automatic pixels(input int first,
                        input int last,
                        input bit inc);
    for (int i = first; i <= last; i++)
      send(inc ? 8'(i) : 8'h01, i == 0);
  endtask

  function automatic int seq_bad(input int n,
                                 input bit dat);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= log_addr.size()) bad++;
      else if (log_addr[i] != i) bad++;
      else if (dat && log_data[i] != i) bad++;
    end
    return bad;
  endfunction

  initial begin
    n_both   = 0;
    rst_n    = 1'b0;
    gpio_pin = '0;
    pi_valid = 1'b0;
    pi_sof   = 1'b0;
    clr();
    idle(2);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_count", frame_count, 0);
    rst_n = 1'b1;
    idle(2);

    // 1: 60 ones, sum 60 = 0x3C
    clr();
    send(8'h01, 1'b1);
    chk("t1_busy_first", busy, 1);
    pixels(1, N - 1, 1'b0);
    idle(1);
    chk("t1_busy_chk", busy, 1);
    chk("t1_writes_pre", n_wr, N);
    send(8'h3C, 1'b0);
    idle(2);
    chk("t1_writes", n_wr, N);
    chk("t1_addr_seq", seq_bad(N, 1'b0), 0);
    chk("t1_done", n_done, 1);
    chk("t1_err", n_err, 0);
    chk("t1_count", frame_count, 1);
    chk("t1_busy_end", busy, 0);

    // 2: bad checksum
    clr();
    pixels(0, N - 1, 1'b0);
    send(8'h3D, 1'b0);
    idle(2);
    chk("t2_writes", n_wr, N);
    chk("t2_err", n_err, 1);
    chk("t2_done", n_done, 0);
    chk("t2_count", frame_count, 1);

    // 3: stray bytes in IDLE; data 0..59, sum 1770 mod 256 = 0xEA
    clr();
    for (int i = 0; i < 5; i++) send(8'hA5, 1'b0);
    idle(2);
    chk("t3_stray_wr", n_wr, 0);
    chk("t3_stray_busy", busy, 0);
    chk("t3_stray_err", n_err, 0);
    pixels(0, N - 1, 1'b1);
    send(8'hEA, 1'b0);
    idle(2);
    chk("t3_writes", n_wr, N);
    chk("t3_seq", seq_bad(N, 1'b1), 0);
    chk("t3_done", n_done, 1);
    chk("t3_count", frame_count, 2);

    // 4: resync SOF at byte 20
    clr();
    pixels(0, 19, 1'b0);
    pixels(0, N - 1, 1'b0);
    idle(1);
    chk("t4_err", n_err, 1);
    chk("t4_err_wen", err_wen, 1);
    chk("t4_err_addr", err_addr, 0);
    send(8'h3C, 1'b0);
    idle(2);
    chk("t4_writes", n_wr, 20 + N);
    chk("t4_done", n_done, 1);
    chk("t4_count", frame_count, 3);

    // 5: stall after 10 bytes
    clr();
    pixels(0, 9, 1'b0);
    idle(TO - 1);
    chk("t5_no_early_err", n_err, 0);
    chk("t5_busy_pre", busy, 1);
    idle(1);
    chk("t5_err_pulse", frame_err, 1);
    chk("t5_busy_post", busy, 0);
    idle(2);
    for (int i = 0; i < 5; i++) send(8'h01, 1'b0);
    idle(2);
    chk("t5_err_cnt", n_err, 1);
    chk("t5_writes", n_wr, 10);
    chk("t5_busy_end", busy, 0);

    // 6: async reset mid-frame, then 256 good frames
    clr();
    pixels(0, 29, 1'b0);
    chk("t6_wr_before", wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", wr_en, 0);
    chk("t6_rst_addr", wr_addr, 0);
    chk("t6_rst_data", wr_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_count", frame_count, 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    clr();
    for (int f = 0; f < 255; f++) begin
      pixels(0, N - 1, 1'b0);
      send(8'h3C, 1'b0);
    end
    idle(2);
    chk("t6_count_255", frame_count, 255);
    pixels(0, N - 1, 1'b0);
    send(8'h3C, 1'b0);
    idle(2);
    chk("t6_count_wrap", frame_count, 0);
    chk("t6_done", n_done, 256);
    chk("t6_err", n_err, 0);
    chk("both_pulses", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
